// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide sequencer.
// The divider is only built when MD_DIV_EN is defined.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam int         MD_ITER     = 32;
  localparam logic [4:0] MD_CNT_LOAD = 5'(MD_ITER - 1);
  localparam logic [31:0] MD_DIV0_Q  = 32'hFFFFFFFF;
  localparam logic [31:0] MD_OVF_Q   = 32'h80000000;

  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_core.sv
// Iterative datapath: 64-bit shift-add multiplier sharing its register with a restoring
// divider ({remainder, quotient}); the divider exists only when MD_DIV_EN is defined.
module md_core (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        i_load,
  input  logic        i_step,
`ifdef MD_DIV_EN
  input  logic        i_div,
`endif
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_acc_nxt
);

  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic [32:0] w_sum;
  logic [63:0] w_mul_nxt;
`ifdef MD_DIV_EN
  logic [32:0] w_tmp;
  logic [32:0] w_diff;
  logic [63:0] w_div_nxt;
`endif

  // Multiplier sits in the low half and is consumed LSB first while the sum shifts in on top.
  assign w_sum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_nxt = {w_sum, r_acc[31:1]};

`ifdef MD_DIV_EN
  // Partial remainder is always below the divisor, so bit 32 of the difference is a clean borrow.
  assign w_tmp     = {r_acc[63:32], r_acc[31]};
  assign w_diff    = w_tmp - {1'b0, r_b};
  assign w_div_nxt = w_diff[32] ? {w_tmp[31:0], r_acc[30:0], 1'b0}
                                : {w_diff[31:0], r_acc[30:0], 1'b1};
  assign o_acc_nxt = i_div ? w_div_nxt : w_mul_nxt;
`else
  assign o_acc_nxt = w_mul_nxt;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= {32'd0, i_a};
      r_b   <= i_b;
    end else if (i_step) begin
      r_acc <= o_acc_nxt;
    end
  end

endmodule

// File: rtl/exe_md_seq.sv
// EXE-stage RV32M sequencer: FSM, iteration counter, special cases, sign correction, outputs.
// Define MD_DIV_EN to build the divider; otherwise div/rem ops complete in one cycle with 0.
module exe_md_seq
  import md_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START_IN,
  input  logic [2:0]  FUNCT3_IN,
  input  logic [31:0] DATO_A_IN,
  input  logic [31:0] DATO_B_IN,
  input  logic        FLUSH_IN,
  output logic        STALL_OUT,
  output logic        VALID_OUT,
  output logic [31:0] RESULT_OUT
);

  md_state_t   r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_lo_sel;
  logic        r_neg;
  logic        r_valid;
  logic [31:0] r_result;
`ifdef MD_DIV_EN
  logic        r_div;
  logic        r_rem;
  logic        r_neg_r;
`endif

  logic        w_start, w_a_sgn, w_b_sgn, w_special;
  logic        w_load, w_step, w_finish, w_stall;
  logic [31:0] w_spec_res, w_final_res, w_mag_a, w_mag_b;
  logic [63:0] w_acc_nxt, w_prod;

  assign w_start = START_IN & ~FLUSH_IN;

  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (FUNCT3_IN)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        w_a_sgn = DATO_A_IN[31];
        w_b_sgn = DATO_B_IN[31];
      end
      MD_MULHSU: w_a_sgn = DATO_A_IN[31];
      default: ;
    endcase
  end

  assign w_mag_a = md_abs(DATO_A_IN, w_a_sgn);
  assign w_mag_b = md_abs(DATO_B_IN, w_b_sgn);

  always_comb begin
    w_special  = 1'b0;
    w_spec_res = '0;
`ifdef MD_DIV_EN
    if (FUNCT3_IN[2]) begin
      if (DATO_B_IN == '0) begin
        w_special  = 1'b1;
        w_spec_res = FUNCT3_IN[1] ? DATO_A_IN : MD_DIV0_Q;
      end else if (!FUNCT3_IN[0] && DATO_A_IN == MD_OVF_Q && DATO_B_IN == 32'hFFFFFFFF) begin
        w_special  = 1'b1;
        w_spec_res = FUNCT3_IN[1] ? 32'd0 : MD_OVF_Q;
      end
    end
`else
    w_special = FUNCT3_IN[2];
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_stall     = 1'b1;
          w_load      = ~w_special;
          w_state_nxt = w_special ? DONE : CALC;
        end
      end
      CALC: begin
        w_stall = 1'b1;
        if (!FLUSH_IN) begin
          w_step = 1'b1;
          if (r_cnt == 5'd0) begin
            w_finish    = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (FLUSH_IN) w_state_nxt = IDLE;
  end

  md_core u_core (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_load    (w_load),
    .i_step    (w_step),
`ifdef MD_DIV_EN
    .i_div     (r_div),
`endif
    .i_a       (w_mag_a),
    .i_b       (w_mag_b),
    .o_acc_nxt (w_acc_nxt)
  );

  // Final value is taken from the step in flight so the result is registered on entry to DONE.
  always_comb begin
    w_prod      = r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
    w_final_res = r_lo_sel ? w_prod[31:0] : w_prod[63:32];
`ifdef MD_DIV_EN
    if (r_div) begin
      w_final_res = r_rem ? md_abs(w_acc_nxt[63:32], r_neg_r) : md_abs(w_acc_nxt[31:0], r_neg);
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt    <= '0;
      r_lo_sel <= 1'b0;
      r_neg    <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
`ifdef MD_DIV_EN
      r_div    <= 1'b0;
      r_rem    <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (r_state == IDLE && w_start) begin
        r_cnt    <= MD_CNT_LOAD;
        r_lo_sel <= (FUNCT3_IN[1:0] == 2'b00);
        r_neg    <= w_a_sgn ^ w_b_sgn;
`ifdef MD_DIV_EN
        r_div    <= FUNCT3_IN[2];
        r_rem    <= FUNCT3_IN[1];
        r_neg_r  <= w_a_sgn;
`endif
        if (w_special) begin
          r_result <= w_spec_res;
          r_valid  <= 1'b1;
        end
      end
      if (w_step && r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
      if (w_finish) begin
        r_result <= w_final_res;
        r_valid  <= 1'b1;
      end
    end
  end

  assign STALL_OUT  = w_stall & RST_N;
  assign VALID_OUT  = r_valid;
  assign RESULT_OUT = r_result;

endmodule

// File: tb/tb_exe_md_seq.sv
// Scoreboard bench for exe_md_seq: directed RV32M cases, flush/reset scenarios and random ops.
// The reference model follows MD_DIV_EN the same way the design does.
module tb_exe_md_seq;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START_IN = 1'b0;
  logic        FLUSH_IN = 1'b0;
  logic [2:0]  FUNCT3_IN = 3'd0;
  logic [31:0] DATO_A_IN = 32'd0;
  logic [31:0] DATO_B_IN = 32'd0;
  logic        STALL_OUT;
  logic        VALID_OUT;
  logic [31:0] RESULT_OUT;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] last_res = 32'd0;

  exe_md_seq dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START_IN   (START_IN),
    .FUNCT3_IN  (FUNCT3_IN),
    .DATO_A_IN  (DATO_A_IN),
    .DATO_B_IN  (DATO_B_IN),
    .FLUSH_IN   (FLUSH_IN),
    .STALL_OUT  (STALL_OUT),
    .VALID_OUT  (VALID_OUT),
    .RESULT_OUT (RESULT_OUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      default: begin
`ifdef MD_DIV_EN
        if (b == 32'd0) return f3[1] ? a : 32'hFFFFFFFF;
        case (f3)
          3'd4: begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            ia = ia / ib;
            return ia;
          end
          3'd6: begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            ia = ia % ib;
            return ia;
          end
          3'd5:    return a / b;
          default: return a % b;
        endcase
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 33;
`ifdef MD_DIV_EN
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int k, lat;
    logic [31:0] e;
    @(posedge CLK); #1;
    START_IN = 1'b1; FUNCT3_IN = f3; DATO_A_IN = a; DATO_B_IN = b;
    k = cyc;
    e = model(f3, a, b);
    lat = latency(f3, a, b);
    exp_q.push_back(e);
    cyc_q.push_back(k + lat);
    last_res = e;
    #1 check("stall_at_start", 32'(STALL_OUT), 32'd1);
    @(posedge CLK); #1;
    START_IN = 1'b0; DATO_A_IN = $urandom; DATO_B_IN = $urandom;
    for (int i = 1; i <= lat; i++) begin
      @(negedge CLK);
      check("stall_during_op", 32'(STALL_OUT), 32'(i < lat));
    end
  endtask

  // Monitor: every VALID_OUT pops one expected result and its expected completion cycle.
  always @(negedge CLK) begin
    if (RST_N && VALID_OUT) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h with no operation pending (cycle %0d)", RESULT_OUT, cyc);
      end else begin
        check("result", RESULT_OUT, exp_q.pop_front());
        check("valid_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  logic [2:0]  d_f3[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a[12]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                            32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b[12]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    // Reset with START asserted: outputs must still read zero.
    START_IN = 1'b1; DATO_A_IN = 32'd7; DATO_B_IN = 32'd3;
    repeat (3) @(negedge CLK);
    check("reset_stall", 32'(STALL_OUT), 32'd0);
    check("reset_valid", 32'(VALID_OUT), 32'd0);
    check("reset_result", RESULT_OUT, 32'd0);
    START_IN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 12; i++) issue(d_f3[i], d_a[i], d_b[i]);

    // Flush mid-operation: back to IDLE, no result, output unchanged.
    issue(3'd0, 32'd9, 32'd11);
    @(posedge CLK); #1;
    START_IN = 1'b1; FUNCT3_IN = 3'd1; DATO_A_IN = 32'h12345678; DATO_B_IN = 32'h9ABCDEF0;
    k = cyc;
    @(posedge CLK); #1;
    START_IN = 1'b0;
    repeat (9) @(posedge CLK);
    #1 FLUSH_IN = 1'b1;
    @(posedge CLK); #1;
    FLUSH_IN = 1'b0;
    @(negedge CLK);
    check("flush_cycle", 32'(cyc), 32'(k + 11));
    check("flush_stall", 32'(STALL_OUT), 32'd0);
    check("flush_result_kept", RESULT_OUT, last_res);
    issue(3'd3, 32'hDEADBEEF, 32'h01234567);

    // START and FLUSH together in IDLE: nothing starts.
    @(posedge CLK); #1;
    START_IN = 1'b1; FLUSH_IN = 1'b1; FUNCT3_IN = 3'd0; DATO_A_IN = 32'd5; DATO_B_IN = 32'd5;
    #1 check("start_flush_stall", 32'(STALL_OUT), 32'd0);
    @(posedge CLK); #1;
    START_IN = 1'b0; FLUSH_IN = 1'b0;
    @(negedge CLK);
    check("start_flush_idle", 32'(STALL_OUT), 32'd0);
    repeat (3) @(negedge CLK);

    // Asynchronous reset mid-operation.
    issue(3'd0, 32'd6, 32'd7);
    @(posedge CLK); #1;
    START_IN = 1'b1; FUNCT3_IN = 3'd0; DATO_A_IN = 32'd5; DATO_B_IN = 32'd6;
    @(posedge CLK); #1;
    START_IN = 1'b0;
    repeat (4) @(posedge CLK);
    #1 START_IN = 1'b1; RST_N = 1'b0;
    #1;
    check("midop_reset_stall", 32'(STALL_OUT), 32'd0);
    check("midop_reset_valid", 32'(VALID_OUT), 32'd0);
    check("midop_reset_result", RESULT_OUT, 32'd0);
    START_IN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    last_res = 32'd0;
    @(negedge CLK);
    check("post_reset_result", RESULT_OUT, 32'd0);
    issue(3'd0, 32'd3, 32'd4);

    for (int i = 0; i < 40; i++) issue(3'($urandom_range(0, 7)), pick(), pick());

    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
